// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, fetches words over imem req/ack, and hands IR to decode with valid/stall.
// Interrupt entry, RTI return and IEN/IOF handling are built only when FETCH_IRQ_EN is defined.
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] IRQ_VECTOR = 16'h0004
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        irq,
    input  logic        IEN_d,
    input  logic        IOF_d,
    input  logic        RTI_d,
    output logic [15:0] IR,
    output logic        IR_valid,
    output logic [15:0] pc_d,
    output logic        int_enabled,
    output logic [15:0] epc
);
    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt, ir_nxt, pc_d_nxt;
    logic        ir_valid_nxt, consume, redirect;

    assign imem_addr = pc;
    assign consume   = IR_valid & ~stall;
    assign imem_req  = (state == FETCH) & (~IR_valid | ~stall);

`ifdef FETCH_IRQ_EN
    logic        irq_redirect, int_en_nxt;
    logic [15:0] epc_nxt;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{irq, IEN_d, IOF_d, RTI_d};
    assign int_enabled       = 1'b0;
    assign epc               = '0;
`endif

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        ir_nxt       = IR;
        ir_valid_nxt = IR_valid;
        pc_d_nxt     = pc_d;
        redirect     = 1'b0;
`ifdef FETCH_IRQ_EN
        irq_redirect = 1'b0;
        int_en_nxt   = int_enabled;
        epc_nxt      = epc;
`endif
        if (state != IDLE) begin
            if (branch_taken) begin
                pc_nxt = branch_target;
            end
`ifdef FETCH_IRQ_EN
            else if (consume & RTI_d) begin
                irq_redirect = 1'b1;
                pc_nxt       = epc;
                int_en_nxt   = 1'b1;
            end else if ((state == FETCH) & int_enabled & irq & (~IR_valid | consume)) begin
                irq_redirect = 1'b1;
                epc_nxt      = pc;
                pc_nxt       = IRQ_VECTOR;
                int_en_nxt   = 1'b0;
            end
            // Enable-flag updates survive a branch but yield to RTI return and interrupt entry.
            if (consume & ~irq_redirect) begin
                if (IEN_d)
                    int_en_nxt = 1'b1;
                else if (IOF_d)
                    int_en_nxt = 1'b0;
            end
            redirect = branch_taken | irq_redirect;
`else
            redirect = branch_taken;
`endif
        end

        if (redirect) begin
            ir_nxt       = '0;
            ir_valid_nxt = 1'b0;
            state_nxt    = FLUSH;
        end else begin
            if (imem_req & imem_ack) begin
                ir_nxt       = imem_rdata;
                pc_d_nxt     = pc;
                ir_valid_nxt = 1'b1;
                pc_nxt       = pc + 16'd1;
            end else if (consume) begin
                ir_valid_nxt = 1'b0;
            end
            if (state != FETCH)
                state_nxt = FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            IR       <= '0;
            IR_valid <= 1'b0;
            pc_d     <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            IR       <= ir_nxt;
            IR_valid <= ir_valid_nxt;
            pc_d     <= pc_d_nxt;
        end
    end

`ifdef FETCH_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_enabled <= 1'b0;
            epc         <= '0;
        end else begin
            int_enabled <= int_en_nxt;
            epc         <= epc_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a rule-level reference model predicts every cycle's outputs and
// every consumed instruction; a separate monitor pops and compares. Follows FETCH_IRQ_EN like the RTL.
module tb_fetch_unit;
    localparam logic [15:0] VEC    = 16'h0004;
    localparam logic [15:0] OP_ION = 16'hF001;
    localparam logic [15:0] OP_IOF = 16'hF002;
    localparam logic [15:0] OP_RTI = 16'hF003;
    localparam int P_IDLE = 0, P_FETCH = 1, P_FLUSH = 2;
`ifdef FETCH_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0;
    logic [15:0] imem_addr, imem_rdata = '0, branch_target = '0;
    logic        imem_req, imem_ack = 1'b0, stall = 1'b0, branch_taken = 1'b0;
    logic        irq = 1'b0, IEN_d = 1'b0, IOF_d = 1'b0, RTI_d = 1'b0;
    logic [15:0] IR, pc_d, epc;
    logic        IR_valid, int_enabled;

    fetch_unit #(.RESET_PC(16'h0000), .IRQ_VECTOR(VEC)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .irq(irq),
        .IEN_d(IEN_d), .IOF_d(IOF_d), .RTI_d(RTI_d), .IR(IR), .IR_valid(IR_valid),
        .pc_d(pc_d), .int_enabled(int_enabled), .epc(epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic req; logic [15:0] addr; logic valid; logic [15:0] ir; logic [15:0] pcd;
        logic ien; logic [15:0] epc;
    } st_t;
    typedef struct { logic [15:0] ir; logic [15:0] pc; } ins_t;
    st_t  st_q[$];
    ins_t ins_q[$];
    int   checks = 0, errors = 0;

    // Reference model state: what the registers should hold after the last clock edge.
    int          m_phase;
    logic [15:0] m_pc, m_ir, m_pcd, m_epc;
    logic        m_valid, m_ien;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit exp_req(input bit st);
        return (m_phase == P_FETCH) && (!m_valid || !st);
    endfunction

    function automatic logic [15:0] mw();
        return m_pc + 16'h1000;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_pc = 16'h0000; m_ir = '0; m_pcd = '0;
        m_epc = '0; m_valid = 1'b0; m_ien = 1'b0;
    endtask

    task automatic model_advance(input bit st, input bit ak, input logic [15:0] rd,
                                 input bit br, input logic [15:0] tgt, input bit iq);
        bit          consume = m_valid && !st;
        bit          req     = exp_req(st);
        bit          irq_jump = 1'b0;
        bit          jump;
        logic [15:0] n_pc = m_pc;
        logic        n_ien = m_ien;
        if (m_phase != P_IDLE && IRQ_ON) begin
            if (br) ;
            else if (consume && m_ir == OP_RTI) begin
                irq_jump = 1'b1; n_pc = m_epc; n_ien = 1'b1;
            end else if (m_phase == P_FETCH && m_ien && iq && (!m_valid || consume)) begin
                irq_jump = 1'b1; m_epc = m_pc; n_pc = VEC; n_ien = 1'b0;
            end
            if (consume && !irq_jump) begin
                if (m_ir == OP_ION) n_ien = 1'b1;
                else if (m_ir == OP_IOF) n_ien = 1'b0;
            end
        end
        jump = (m_phase != P_IDLE) && (br || irq_jump);
        if (m_phase != P_IDLE && br) n_pc = tgt;
        if (jump) begin
            m_ir = '0; m_valid = 1'b0; m_phase = P_FLUSH;
        end else begin
            if (req && ak) begin
                m_ir = rd; m_pcd = m_pc; m_valid = 1'b1; n_pc = m_pc + 16'h0001;
            end else if (consume) begin
                m_valid = 1'b0;
            end
            m_phase = P_FETCH;
        end
        m_pc = n_pc; m_ien = n_ien;
    endtask

    // One clock cycle: drive inputs at the falling edge, queue expectations, advance the model.
    task automatic step(input bit rst, input bit st, input bit ak, input logic [15:0] rd,
                        input bit br, input logic [15:0] tgt, input bit iq);
        @(negedge clk);
        if (rst) model_reset();
        reset = rst; stall = st; imem_ack = ak; imem_rdata = rd;
        branch_taken = br; branch_target = tgt; irq = iq;
        IEN_d = (m_ir == OP_ION); IOF_d = (m_ir == OP_IOF); RTI_d = (m_ir == OP_RTI);
        st_q.push_back('{exp_req(st), m_pc, m_valid, m_ir, m_pcd, m_ien, m_epc});
        if (m_valid && !st) ins_q.push_back('{m_ir, m_pcd});
        if (!rst) model_advance(st, ak, rd, br, tgt, iq);
    endtask

    task automatic fetch(input bit st, input bit ak, input logic [15:0] rd, input bit iq);
        step(1'b0, st, ak && exp_req(st), rd, 1'b0, 16'h0000, iq);
    endtask

    initial begin : monitor
        st_t  s;
        ins_t e;
        forever begin
            @(negedge clk);
            #2;
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                check("imem_req", 16'(imem_req), 16'(s.req));
                check("imem_addr", imem_addr, s.addr);
                check("IR_valid", 16'(IR_valid), 16'(s.valid));
                check("IR", IR, s.ir);
                check("pc_d", pc_d, s.pcd);
                check("int_enabled", 16'(int_enabled), 16'(s.ien));
                check("epc", epc, s.epc);
                if (IR_valid && !stall) begin
                    if (ins_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL consume at %0t: IR %h consumed, none expected", $time, IR);
                    end else begin
                        e = ins_q.pop_front();
                        check("consumed_IR", IR, e.ir);
                        check("consumed_pc_d", pc_d, e.pc);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        bit          st, ak, br, iq, rst;
        logic [15:0] rd, tgt;
        int unsigned r;
        model_reset();
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        // Zero-wait stream from address 0, then a 3-cycle stall holding IR=1002.
        repeat (4) fetch(1'b0, 1'b1, mw(), 1'b0);
        repeat (3) fetch(1'b1, 1'b1, mw(), 1'b0);
        repeat (2) fetch(1'b0, 1'b1, mw(), 1'b0);
        // Branch to 0x40 with an ack in the same cycle.
        step(1'b0, 1'b0, exp_req(1'b0), mw(), 1'b1, 16'h0040, 1'b0);
        repeat (3) fetch(1'b0, 1'b1, mw(), 1'b0);
        // Wrap at 0xFFFF with two wait cycles.
        step(1'b0, 1'b0, 1'b0, mw(), 1'b1, 16'hFFFF, 1'b0);
        fetch(1'b0, 1'b0, mw(), 1'b0);
        repeat (2) fetch(1'b0, 1'b0, mw(), 1'b0);
        repeat (3) fetch(1'b0, 1'b1, mw(), 1'b0);
        // Interrupt round trip: ION at 0x0E, irq at PC=0x10, RTI at the vector.
        step(1'b0, 1'b0, 1'b0, mw(), 1'b1, 16'h000E, 1'b0);
        fetch(1'b0, 1'b0, mw(), 1'b0);
        fetch(1'b0, 1'b1, OP_ION, 1'b0);
        fetch(1'b0, 1'b1, mw(), 1'b0);
        fetch(1'b0, 1'b1, mw(), 1'b1);
        fetch(1'b0, 1'b0, mw(), 1'b0);
        fetch(1'b0, 1'b1, OP_RTI, 1'b0);
        repeat (4) fetch(1'b0, 1'b1, mw(), 1'b0);
        // Reset in the middle of a waited fetch.
        fetch(1'b0, 1'b0, mw(), 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        repeat (3) fetch(1'b0, 1'b1, mw(), 1'b0);
        // Randomized traffic.
        iq = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            st  = ($urandom_range(0, 3) == 0);
            ak  = exp_req(st) && ($urandom_range(0, 2) != 0);
            r   = $urandom_range(0, 19);
            rd  = (r == 0) ? OP_ION : (r == 1) ? OP_IOF : (r == 2) ? OP_RTI : mw();
            br  = (m_phase == P_FETCH) && ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 7) == 0) iq = ~iq;
            step(rst, st, ak && !rst, rd, br && !rst, tgt, iq);
        end
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        #3;
        check("ins_q_drained", 16'(ins_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
